// File: rtl/vmem_fill.sv
// Rectangle-fill engine in front of the vmem write port.
// CPU pixel writes win; the engine stalls and resumes in raster order.
module vmem_fill (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_we_i,
  input  logic [1:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  output logic [31:0] cfg_rdata_o,
  input  logic        cpu_vmem_we_i,
  input  logic [15:0] cpu_vmem_addr_i,
  input  logic [15:0] cpu_vmem_wdata_i,
  output logic        vmem_we_o,
  output logic [15:0] vmem_addr_o,
  output logic [15:0] vmem_wdata_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q;
  logic [7:0]  x0_q, y0_q, wm1_q, hm1_q;
  logic [15:0] color_q;
  logic [7:0]  lx0_q, lwm1_q, lhm1_q;
  logic [7:0]  cx_q, cy_q, i_q, j_q;
  logic [15:0] lcol_q;
  logic        done_q, flag_q;
  logic [31:0] rdata_q, rdata_d;

  logic ctrl_we, start, abort, eng_we, row_end, last;
  logic unused_wdata;

  assign unused_wdata = ^cfg_wdata_i[31:16];

  assign ctrl_we = cfg_we_i && (cfg_addr_i == 2'd3);
  assign start   = ctrl_we && cfg_wdata_i[0];
  assign abort   = ctrl_we && cfg_wdata_i[1];
  assign eng_we  = (state_q == RUN) && !cpu_vmem_we_i;
  assign row_end = (i_q == lwm1_q);
  assign last    = row_end && (j_q == lhm1_q);

  always_comb begin
    rdata_d = 32'd0;
    unique case (cfg_addr_i)
      2'd0: rdata_d = {16'd0, y0_q, x0_q};
      2'd1: rdata_d = {16'd0, hm1_q, wm1_q};
      2'd2: rdata_d = {16'd0, color_q};
      2'd3: rdata_d = {30'd0, flag_q, state_q == RUN};
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      wm1_q   <= '0;
      hm1_q   <= '0;
      color_q <= '0;
      lx0_q   <= '0;
      lwm1_q  <= '0;
      lhm1_q  <= '0;
      lcol_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      done_q  <= 1'b0;
      flag_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      done_q  <= 1'b0;
      if (cfg_we_i) begin
        unique case (cfg_addr_i)
          2'd0: {y0_q, x0_q}   <= cfg_wdata_i[15:0];
          2'd1: {hm1_q, wm1_q} <= cfg_wdata_i[15:0];
          2'd2: color_q        <= cfg_wdata_i[15:0];
          2'd3: ;
        endcase
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            lx0_q   <= x0_q;
            lwm1_q  <= wm1_q;
            lhm1_q  <= hm1_q;
            lcol_q  <= color_q;
            cx_q    <= x0_q;
            cy_q    <= y0_q;
            i_q     <= '0;
            j_q     <= '0;
            flag_q  <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (eng_we) begin
            if (last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              flag_q  <= 1'b1;
            end else if (row_end) begin
              i_q  <= '0;
              cx_q <= lx0_q;
              cy_q <= cy_q + 8'd1;
              j_q  <= j_q + 8'd1;
            end else begin
              i_q  <= i_q + 8'd1;
              cx_q <= cx_q + 8'd1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    vmem_we_o    = 1'b0;
    vmem_addr_o  = {cy_q, cx_q};
    vmem_wdata_o = lcol_q;
    if (cpu_vmem_we_i) begin
      vmem_we_o    = 1'b1;
      vmem_addr_o  = cpu_vmem_addr_i;
      vmem_wdata_o = cpu_vmem_wdata_i;
    end else if (eng_we) begin
      vmem_we_o = 1'b1;
    end
  end

  assign cfg_rdata_o = rdata_q;
  assign busy_o      = (state_q == RUN);
  assign done_o      = done_q;

endmodule

// File: tb/tb_vmem_fill.sv
// Bench for vmem_fill: pixel-list reference model checked every cycle,
// directed scenarios with literal expectations, then random fills.
module tb_vmem_fill;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_data = '0;
  logic        vmem_we;
  logic [15:0] vmem_addr, vmem_wdata;
  logic        busy, done;

  vmem_fill dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata),
    .cpu_vmem_we_i(cpu_we), .cpu_vmem_addr_i(cpu_addr),
    .cpu_vmem_wdata_i(cpu_data),
    .vmem_we_o(vmem_we), .vmem_addr_o(vmem_addr),
    .vmem_wdata_o(vmem_wdata),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
  endtask

  // Reference model: stored registers plus the list of pixels still owed.
  logic [15:0] r_org, r_size, r_col, m_col;
  logic        m_busy, m_done, m_flag;
  logic [31:0] m_rdata, nx_rdata;
  logic [15:0] q[$];
  logic [7:0]  tx, ty;
  logic [15:0] eng_log[$];
  int          done_pulses = 0;
  int          busy_cycles = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      r_org = 0; r_size = 0; r_col = 0; m_col = 0;
      m_busy = 0; m_done = 0; m_flag = 0; m_rdata = 0;
      q.delete();
    end
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("rdata", cfg_rdata, m_rdata);
    if (cpu_we) begin
      chk("cpu_we", vmem_we, 1);
      chk("cpu_addr", vmem_addr, cpu_addr);
      chk("cpu_data", vmem_wdata, cpu_data);
    end else if (m_busy && q.size() > 0) begin
      chk("eng_we", vmem_we, 1);
      chk("eng_addr", vmem_addr, q[0]);
      chk("eng_data", vmem_wdata, m_col);
    end else begin
      chk("idle_we", vmem_we, 0);
    end
    if (done) done_pulses++;
    if (busy) busy_cycles++;
    if (vmem_we && !cpu_we) eng_log.push_back(vmem_addr);
    if (rst_n) begin
      case (cfg_addr)
        2'd0: nx_rdata = {16'd0, r_org};
        2'd1: nx_rdata = {16'd0, r_size};
        2'd2: nx_rdata = {16'd0, r_col};
        default: nx_rdata = {30'd0, m_flag, m_busy};
      endcase
      m_rdata = nx_rdata;
      m_done = 0;
      if (m_busy) begin
        if (cfg_we && cfg_addr == 3 && cfg_wdata[1]) begin
          m_busy = 0;
        end else if (!cpu_we) begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            m_busy = 0; m_done = 1; m_flag = 1;
          end
        end
      end else if (cfg_we && cfg_addr == 3 && cfg_wdata[0]) begin
        q.delete();
        for (int j = 0; j <= int'(r_size[15:8]); j++)
          for (int i = 0; i <= int'(r_size[7:0]); i++) begin
            ty = r_org[15:8] + 8'(j);
            tx = r_org[7:0] + 8'(i);
            q.push_back({ty, tx});
          end
        m_col = r_col; m_busy = 1; m_flag = 0;
      end
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: r_org = cfg_wdata[15:0];
          2'd1: r_size = cfg_wdata[15:0];
          2'd2: r_col = cfg_wdata[15:0];
          default: ;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin tick(); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  logic [15:0] exp_basic [8] = '{16'h0A05, 16'h0A06, 16'h0A07, 16'h0A08,
                                 16'h0B05, 16'h0B06, 16'h0B07, 16'h0B08};
  logic [15:0] exp_wrap [3] = '{16'hFFFE, 16'hFFFF, 16'hFF00};
  int dp, n;

  initial begin
    cpu_we = 1; cpu_addr = 16'h5555; cpu_data = 16'h1234;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_rdata", cfg_rdata, 0);
    chk("rst_we_follow", vmem_we, 1);
    cpu_we = 0;
    rst_n = 1;
    tick();

    // basic 4x2
    wr(0, 32'h0A05); wr(1, 32'h0103); wr(2, 32'hF800);
    eng_log.delete(); busy_cycles = 0; done_pulses = 0;
    wr(3, 32'h1);
    wait_idle(50);
    cfg_addr = 3;
    tick();
    chk("basic_n", eng_log.size(), 8);
    for (int k = 0; k < 8 && k < eng_log.size(); k++)
      chk("basic_addr", eng_log[k], exp_basic[k]);
    chk("basic_cycles", busy_cycles, 8);
    chk("basic_done", done_pulses, 1);
    chk("basic_ctrl", cfg_rdata, 32'h2);

    // contention
    eng_log.delete(); busy_cycles = 0;
    wr(3, 32'h1);
    tick(); tick(); tick();
    cpu_we = 1; cpu_addr = 16'h1234; cpu_data = 16'hABCD;
    tick(); tick();
    cpu_we = 0;
    wait_idle(50);
    chk("cont_cycles", busy_cycles, 10);
    chk("cont_n", eng_log.size(), 8);
    for (int k = 0; k < 8 && k < eng_log.size(); k++)
      chk("cont_addr", eng_log[k], exp_basic[k]);

    // wrap
    wr(0, 32'hFFFE); wr(1, 32'h0002);
    eng_log.delete();
    wr(3, 32'h1);
    wait_idle(20);
    chk("wrap_n", eng_log.size(), 3);
    for (int k = 0; k < 3 && k < eng_log.size(); k++)
      chk("wrap_addr", eng_log[k], exp_wrap[k]);

    // abort and restart
    wr(0, 32'h1020); wr(1, 32'hFFFF);
    eng_log.delete(); dp = done_pulses;
    wr(3, 32'h1);
    repeat (100) tick();
    wr(3, 32'h2);
    chk("abort_busy", busy, 0);
    tick(); tick();
    chk("abort_nodone", done_pulses, dp);
    chk("abort_n", eng_log.size(), 101);
    eng_log.delete();
    wr(3, 32'h1);
    tick();
    chk("restart_n", eng_log.size(), 1);
    if (eng_log.size() > 0) chk("restart_org", eng_log[0], 16'h1020);
    wr(3, 32'h2);

    // register hazards
    wr(0, 32'h3030); wr(1, 32'h0303); wr(2, 32'h1111);
    busy_cycles = 0;
    wr(3, 32'h1);
    tick(); tick();
    wr(3, 32'h1);
    wr(2, 32'h2222);
    cfg_addr = 2;
    tick();
    chk("haz_color_rd", cfg_rdata, 32'h2222);
    wait_idle(50);
    chk("haz_cycles", busy_cycles, 16);
    wr(3, 32'h1);
    chk("haz_new_we", vmem_we, 1);
    chk("haz_new_col", vmem_wdata, 16'h2222);
    wait_idle(50);

    // random fills with CPU contention and register traffic
    for (int it = 0; it < 30; it++) begin
      wr(0, $urandom);
      wr(1, ($urandom_range(0, 3) << 8) | $urandom_range(0, 7));
      wr(2, $urandom);
      wr(3, 32'h1);
      n = 0;
      while (busy && n < 200) begin
        cpu_we = ($urandom_range(0, 3) == 0);
        cpu_addr = 16'($urandom);
        cpu_data = 16'($urandom);
        cfg_addr = 2'($urandom);
        if ($urandom_range(0, 9) == 0) begin
          cfg_we = 1;
          cfg_addr = 2'($urandom_range(0, 2));
          cfg_wdata = $urandom;
        end
        tick();
        cfg_we = 0;
        n++;
      end
      cpu_we = 0;
      chk("rand_timeout", busy, 0);
      tick();
    end

    // async reset mid-fill
    wr(0, 32'h0000); wr(1, 32'hFFFF); wr(2, 32'h07E0);
    wr(3, 32'h1);
    repeat (5) tick();
    rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_we", vmem_we, 0);
    tick(); tick();
    rst_n = 1;
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a);
      tick();
      chk("arst_reg", cfg_rdata, 0);
    end
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vmem_fill.md
# vmem_fill

Memory-mapped rectangle-fill engine that sits directly upstream of the 16-bit video memory (240x240 RGB565 frame, address {y[7:0], x[7:0]}). The CPU programs origin, size and colour over a small register window, then starts the engine. The engine writes one pixel per cycle into the vmem write port in raster order, and the CPU's own vmem writes have priority. The vmem's write port is driven solely by this block; the display scan-out side of vmem is unaffected.

## Interface
Parameters:
- none (coordinate width fixed at 8 bits, colour at 16 bits)

Ports:
- clk_i  in  1  system clock; one clock domain
- rst_ni  in  1  reset, asynchronous, active-low
- cfg_we_i  in  1  register write strobe (CPU dbus write decoded to this block)
- cfg_addr_i  in  2  register word index (dbus_addr[3:2])
- cfg_wdata_i  in  32  register write data
- cfg_rdata_o  out  32  registered read data for cfg_addr_i
- cpu_vmem_we_i  in  1  CPU direct pixel write strobe
- cpu_vmem_addr_i  in  16  CPU pixel address
- cpu_vmem_wdata_i  in  16  CPU pixel data
- vmem_we_o  out  1  write strobe to vmem
- vmem_addr_o  out  16  write address to vmem, {y, x}
- vmem_wdata_o  out  16  write data to vmem
- busy_o  out  1  high while state is RUN
- done_o  out  1  one-cycle pulse after the final pixel write of a completed fill

## Operation
- Registers (index: field):
  - 0 ORIGIN: x0=[7:0], y0=[15:8]
  - 1 SIZE: wm1=[7:0], hm1=[15:8]; width=wm1+1 and height=hm1+1 (1..256 each)
  - 2 COLOR: [15:0]
  - 3 CTRL: write bit0=START, bit1=ABORT; read value is {30'b0, done_flag, busy}
- Reads of 0-2 return the stored fields zero-extended. Unused write bits are ignored.
- FSM with two states, IDLE and RUN.
- IDLE -> RUN on a CTRL write with START=1. This latches x0, y0, wm1, hm1, COLOR into working copies, sets cx=x0, cy=y0, i=0, j=0, and clears done_flag.
- In RUN, each cycle with cpu_vmem_we_i=0 is an engine write: {cy, cx} with the latched colour.
  - Then cx++ and i++. When i==wm1: i=0, cx=x0, cy++, j++.
  - A cycle with cpu_vmem_we_i=1 stalls the engine; the counters hold.
- RUN -> IDLE on the edge that commits the engine write with i==wm1 && j==hm1. On that edge done_o (registered) is set for the next cycle, and done_flag is set.
- ABORT=1 while in RUN -> IDLE on that edge. No done_o pulse, done_flag unchanged. Pixels already written stay written.
- START while in RUN is ignored. START and ABORT both set in IDLE: START wins.
- Register writes to 0-2 during RUN update the stored registers only. The fill in progress uses its latched copies.
- Coordinate arithmetic is 8-bit modulo 256: cx and cy wrap past 255. No clipping to 240; off-screen addresses are written harmlessly.
- Output mux is combinational:
  - when cpu_vmem_we_i=1, vmem_* = cpu_vmem_*;
  - else when in RUN, vmem_* = engine write;
  - else vmem_we_o=0.

## Timing
- Reset (rst_ni=0, asynchronous) forces:
  - state=IDLE, busy_o=0, done_o=0, done_flag=0
  - all registers 0; cfg_rdata_o=0
  - vmem_we_o follows cpu_vmem_we_i only
- Reset asserted mid-fill aborts immediately, with no done pulse.
- cfg_rdata_o is registered from cfg_addr_i every clock; data appears one cycle after the address.
- START written at edge k:
  - busy_o=1 from edge k.
  - First engine write is presented during cycle k+1 and committed at edge k+1.
- With no contention, a fill of W x H pixels occupies edges k+1..k+W*H.
  - busy_o falls at edge k+W*H.
  - done_o is high for the single cycle between edges k+W*H and k+W*H+1.
- Each CPU vmem write during RUN adds exactly one cycle to the fill.
- A CPU vmem write in the same cycle as an engine-pending write: the CPU write goes out, and the engine write is issued next free cycle.

## Test plan
- Basic 4x2 fill:
  - Stimulus: ORIGIN=0x0A05, SIZE=0x0103, COLOR=0xF800, START.
  - Response: 8 consecutive writes to 0x0A05..0x0A08, then 0x0B05..0x0B08, all 0xF800. done_o pulses once, CTRL reads 0x2.
- Contention:
  - Stimulus: same fill with cpu_vmem_we_i=1 for two cycles mid-fill (addr 0x1234, data 0xABCD).
  - Response: CPU writes appear unchanged, the engine sequence is intact, and the fill takes 10 cycles.
- Wrap:
  - Stimulus: ORIGIN=0xFFFE, SIZE=0x0002 (3x1).
  - Response: writes to 0xFFFE, 0xFFFF, 0xFF00.
- Abort and restart:
  - Stimulus: 256x256 fill, ABORT after 100 writes; then START.
  - Response: busy_o drops and there is no done_o pulse. The restarted fill begins again at the origin.
- Register hazards:
  - Stimulus: START during RUN; COLOR write during RUN.
  - Response: both are ignored by the active fill. The COLOR register read-back shows the new value, which a later START uses.
- Async reset mid-fill:
  - Stimulus: rst_ni low between edges.
  - Response: busy_o=0 and vmem_we_o=0 immediately. All registers read 0 afterwards.
